lockstep_miter_seq: RTL and testbench

- Synthesizable sequential miter for gold-vs-gate equivalence runs on the AES ASAP7 flow.
- Successor to the flat, single-bit, combinational gold/gate output compare. Adds:
  - parametrised width;
  - gold-side latency alignment (skew);
  - per-bit don't-care masking;
  - valid-stream checking;
  - sticky failure state with error counters and first-mismatch capture.
- Sits between the instantiated gold and gate netlists in an emulation or FPGA bring-up harness, and inside eqy/sby sequential partitions.

---
 rtl/lockstep_miter_pkg.sv | 24 ++
 rtl/lockstep_miter_seq_if.sv | 23 ++
 rtl/miter_skew_line.sv | 43 ++++
 rtl/lockstep_miter_seq.sv | 158 +++++++++++++++
 tb/tb_lockstep_miter_seq.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lockstep_miter_pkg.sv
// Shared types and helpers for the lockstep sequential miter.
// Optional build macro used by the top: LOCKSTEP_MITER_DIFFMAP_EN.
package lockstep_miter_pkg;

    // Miter control state; also exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAIL   = 2'd3
    } state_t;

    // Largest supported gold-side alignment delay.
    localparam int SKEW_MAX = 15;

    // Saturating increment for a counter of w bits (w <= 32) carried in a
    // 32-bit container; the caller narrows the result back to its width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt >= lim) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/lockstep_miter_seq_if.sv
// Gold and gate sample streams feeding the miter.
//
// Handshake: both streams are valid-only. A sample is transferred on every
// rising clk edge where its *_vld is high; there is no ready, so the miter
// never stalls either producer. gold_care qualifies gold_data bit by bit
// (0 = that gold bit is don't-care) and travels with the gold sample.
interface lockstep_miter_seq_if #(
    parameter int WIDTH = 8
);
    logic             gold_vld;
    logic [WIDTH-1:0] gold_data;
    logic [WIDTH-1:0] gold_care;
    logic             gate_vld;
    logic [WIDTH-1:0] gate_data;

    modport master (
        output gold_vld, gold_data, gold_care, gate_vld, gate_data
    );

    modport slave (
        input  gold_vld, gold_data, gold_care, gate_vld, gate_data
    );
endinterface

// File: rtl/miter_skew_line.sv
// Gold-side delay line: SKEW register stages on {vld, care, data}.
// SKEW = 0 is a plain combinational pass-through. The line shifts every
// cycle regardless of miter state; flush empties it to invalid samples.
module miter_skew_line #(
    parameter int WIDTH = 8,
    parameter int SKEW  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_care,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_care,
    output logic [WIDTH-1:0] out_data
);
    generate
        if (SKEW == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, flush};
            assign out_vld    = in_vld;
            assign out_care   = in_care;
            assign out_data   = in_data;
        end else begin : g_pipe
            logic [2*WIDTH:0] pipe_q [SKEW];

            // Shift one stage per cycle; flush and reset drop every stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SKEW; i++) pipe_q[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < SKEW; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= {in_vld, in_care, in_data};
                    for (int i = 1; i < SKEW; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign {out_vld, out_care, out_data} = pipe_q[SKEW-1];
        end
    endgenerate
endmodule

// File: rtl/lockstep_miter_seq.sv
// Sequential gold-vs-gate miter: aligns the gold stream by SKEW cycles,
// compares masked data and valid timing, counts beats and errors, and
// captures the first failing beat. Counters are CNT_W <= 32 bits wide.
// Build macro LOCKSTEP_MITER_DIFFMAP_EN enables the sticky diff_bits map;
// without it diff_bits is constant 0.
module lockstep_miter_seq
    import lockstep_miter_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SKEW         = 0,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  clear,
    lockstep_miter_seq_if.slave   bus,
    output logic                  busy,
    output logic                  mismatch,
    output logic                  fail,
    output logic [CNT_W-1:0]      chk_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      first_idx,
    output logic [WIDTH-1:0]      first_gold,
    output logic [WIDTH-1:0]      first_gate,
    output logic                  vld_err,
    output logic [WIDTH-1:0]      diff_bits,
    output state_t                dbg_state
);
    localparam int WARM_W = $clog2(SKEW_MAX + 1);
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'((SKEW > 0) ? SKEW - 1 : 0);

    state_t             state;
    logic [WARM_W-1:0]  warm_q;

    logic               a_vld;
    logic [WIDTH-1:0]   a_care;
    logic [WIDTH-1:0]   a_data;

    miter_skew_line #(
        .WIDTH (WIDTH),
        .SKEW  (SKEW)
    ) u_skew (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear),
        .in_vld   (bus.gold_vld),
        .in_care  (bus.gold_care),
        .in_data  (bus.gold_data),
        .out_vld  (a_vld),
        .out_care (a_care),
        .out_data (a_data)
    );

    // A beat is any cycle with either side valid; it is an error when the
    // valids disagree or when cared-about data bits differ.
    logic               beat;
    logic               both_vld;
    logic [WIDTH-1:0]   data_diff;
    logic               err_now;
    logic               compare_en;
    logic [CNT_W-1:0]   chk_next;
    logic [CNT_W-1:0]   err_next;

    assign beat       = a_vld | bus.gate_vld;
    assign both_vld   = a_vld & bus.gate_vld;
    assign data_diff  = (a_data ^ bus.gate_data) & a_care;
    assign err_now    = (a_vld ^ bus.gate_vld) | (both_vld & (|data_diff));
    assign compare_en = (state == CHECK) && arm;
    assign chk_next   = CNT_W'(sat_inc(32'(chk_cnt), CNT_W));
    assign err_next   = CNT_W'(sat_inc(32'(err_cnt), CNT_W));

    // Control FSM with counters and first-error capture; clear beats everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            warm_q     <= '0;
            mismatch   <= 1'b0;
            fail       <= 1'b0;
            vld_err    <= 1'b0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
            first_idx  <= '0;
            first_gold <= '0;
            first_gate <= '0;
        end else begin
            mismatch <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                warm_q     <= '0;
                fail       <= 1'b0;
                vld_err    <= 1'b0;
                chk_cnt    <= '0;
                err_cnt    <= '0;
                first_idx  <= '0;
                first_gold <= '0;
                first_gate <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            if (SKEW > 0) begin
                                state  <= WARMUP;
                                warm_q <= WARM_LOAD;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                    WARMUP: begin
                        if (!arm)             state  <= IDLE;
                        else if (warm_q == '0) state <= CHECK;
                        else                   warm_q <= warm_q - 1'b1;
                    end
                    CHECK: begin
                        if (!arm) begin
                            state <= IDLE;
                        end else if (beat) begin
                            chk_cnt <= chk_next;
                            if (err_now) begin
                                mismatch <= 1'b1;
                                err_cnt  <= err_next;
                                if (!fail) begin
                                    fail       <= 1'b1;
                                    first_idx  <= chk_cnt;
                                    first_gold <= a_data;
                                    first_gate <= bus.gate_data;
                                    vld_err    <= a_vld ^ bus.gate_vld;
                                end
                                if (STOP_ON_FAIL) state <= FAIL;
                            end
                        end
                    end
                    FAIL: begin
                        state <= FAIL;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LOCKSTEP_MITER_DIFFMAP_EN
    // Sticky map of every cared bit that differed on a valid-valid compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       diff_bits <= '0;
        else if (clear)                 diff_bits <= '0;
        else if (compare_en && both_vld) diff_bits <= diff_bits | data_diff;
    end
`else
    assign diff_bits = '0;
`endif

    assign busy      = (state == WARMUP) || (state == CHECK);
    assign dbg_state = state;

endmodule

// File: tb/tb_lockstep_miter_seq.sv
// Bench for lockstep_miter_seq: two instances (A: SKEW=2, CNT_W=4, no stop;
// B: SKEW=0, CNT_W=16, stop on fail) against a time-based reference model.
module tb_lockstep_miter_seq;
    import lockstep_miter_pkg::*;

    localparam int W      = 8;
    localparam int SKEW_A = 2;
    localparam int CNTW_A = 4;
    localparam int SKEW_B = 0;
    localparam int CNTW_B = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic arm_a, clear_a, arm_b, clear_b;

    lockstep_miter_seq_if #(.WIDTH(W)) bus_a ();
    lockstep_miter_seq_if #(.WIDTH(W)) bus_b ();

    logic              a_busy, a_mis, a_fail, a_verr;
    logic [CNTW_A-1:0] a_chk, a_err, a_fidx;
    logic [W-1:0]      a_fgold, a_fgate, a_diff;
    state_t            a_state;
    logic              b_busy, b_mis, b_fail, b_verr;
    logic [CNTW_B-1:0] b_chk, b_err, b_fidx;
    logic [W-1:0]      b_fgold, b_fgate, b_diff;
    state_t            b_state;

    lockstep_miter_seq #(.WIDTH(W), .SKEW(SKEW_A), .CNT_W(CNTW_A), .STOP_ON_FAIL(1'b0)) u_a (
        .clk(clk), .rst(rst), .arm(arm_a), .clear(clear_a), .bus(bus_a),
        .busy(a_busy), .mismatch(a_mis), .fail(a_fail), .chk_cnt(a_chk), .err_cnt(a_err),
        .first_idx(a_fidx), .first_gold(a_fgold), .first_gate(a_fgate), .vld_err(a_verr),
        .diff_bits(a_diff), .dbg_state(a_state)
    );

    lockstep_miter_seq #(.WIDTH(W), .SKEW(SKEW_B), .CNT_W(CNTW_B), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .rst(rst), .arm(arm_b), .clear(clear_b), .bus(bus_b),
        .busy(b_busy), .mismatch(b_mis), .fail(b_fail), .chk_cnt(b_chk), .err_cnt(b_err),
        .first_idx(b_fidx), .first_gold(b_fgold), .first_gate(b_fgate), .vld_err(b_verr),
        .diff_bits(b_diff), .dbg_state(b_state)
    );

    // ---------------- reference model ----------------
    // Compares happen only once arm has been high for more than SKEW
    // consecutive edges since the last idle/clear; hist[i][k] is the gold
    // input k+1 cycles ago, so the aligned gold is the input SKEW cycles ago.
    typedef struct packed { logic vld; logic [W-1:0] care; logic [W-1:0] data; } gold_t;

    int          skew_of [2];
    int          cntw_of [2];
    bit          stop_of [2];
    gold_t       hist    [2][16];
    int          m_run   [2];
    logic        m_stop  [2];
    logic [31:0] m_chk   [2];
    logic [31:0] m_err   [2];
    logic [31:0] m_fidx  [2];
    logic [W-1:0] m_fgold[2];
    logic [W-1:0] m_fgate[2];
    logic [W-1:0] m_diff [2];
    logic        m_fail  [2];
    logic        m_verr  [2];
    logic        m_mis   [2];
    logic        m_busy  [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sd [32];
    logic [W-1:0] sx [32];

    function automatic logic [31:0] lim_of(input int i);
        return (32'd1 << cntw_of[i]) - 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) hist[i][k] = '0;
            m_run[i] = 0;   m_stop[i] = 1'b0; m_chk[i] = '0;  m_err[i] = '0;
            m_fidx[i] = '0; m_fgold[i] = '0;  m_fgate[i] = '0; m_diff[i] = '0;
            m_fail[i] = 1'b0; m_verr[i] = 1'b0; m_mis[i] = 1'b0; m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic arm, input logic clr,
                              input logic gv, input logic [W-1:0] gc, input logic [W-1:0] gd,
                              input logic tv, input logic [W-1:0] td);
        gold_t cur, al;
        logic  bad;
        cur = {gv, gc, gd};
        if (skew_of[i] == 0) al = cur;
        else                 al = hist[i][skew_of[i]-1];
        for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = cur;
        m_mis[i] = 1'b0;
        if (clr) begin
            for (int k = 0; k < 16; k++) hist[i][k] = '0;
            m_run[i] = 0;   m_stop[i] = 1'b0; m_chk[i] = '0;  m_err[i] = '0;
            m_fidx[i] = '0; m_fgold[i] = '0;  m_fgate[i] = '0; m_diff[i] = '0;
            m_fail[i] = 1'b0; m_verr[i] = 1'b0; m_busy[i] = 1'b0;
            return;
        end
        if (arm && !m_stop[i] && m_run[i] > skew_of[i] && (al.vld || tv)) begin
            bad = (al.vld != tv) || (al.vld && tv && (((al.data ^ td) & al.care) != '0));
            if (bad) begin
                m_mis[i] = 1'b1;
                if (m_err[i] < lim_of(i)) m_err[i] = m_err[i] + 1;
                if (!m_fail[i]) begin
                    m_fail[i]  = 1'b1;
                    m_fidx[i]  = m_chk[i];
                    m_fgold[i] = al.data;
                    m_fgate[i] = td;
                    m_verr[i]  = (al.vld != tv);
                end
                if (stop_of[i]) m_stop[i] = 1'b1;
            end
`ifdef LOCKSTEP_MITER_DIFFMAP_EN
            if (al.vld && tv) m_diff[i] = m_diff[i] | ((al.data ^ td) & al.care);
`endif
            if (m_chk[i] < lim_of(i)) m_chk[i] = m_chk[i] + 1;
        end
        m_busy[i] = m_stop[i] ? 1'b0 : arm;
        if (!arm)            m_run[i] = 0;
        else if (!m_stop[i]) m_run[i] = m_run[i] + 1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_one("a_busy",       32'(a_busy),  32'(m_busy[0]));
        check_one("a_mismatch",   32'(a_mis),   32'(m_mis[0]));
        check_one("a_fail",       32'(a_fail),  32'(m_fail[0]));
        check_one("a_chk_cnt",    32'(a_chk),   m_chk[0]);
        check_one("a_err_cnt",    32'(a_err),   m_err[0]);
        check_one("a_first_idx",  32'(a_fidx),  m_fidx[0]);
        check_one("a_first_gold", 32'(a_fgold), 32'(m_fgold[0]));
        check_one("a_first_gate", 32'(a_fgate), 32'(m_fgate[0]));
        check_one("a_vld_err",    32'(a_verr),  32'(m_verr[0]));
        check_one("a_diff_bits",  32'(a_diff),  32'(m_diff[0]));
        check_one("b_busy",       32'(b_busy),  32'(m_busy[1]));
        check_one("b_mismatch",   32'(b_mis),   32'(m_mis[1]));
        check_one("b_fail",       32'(b_fail),  32'(m_fail[1]));
        check_one("b_chk_cnt",    32'(b_chk),   m_chk[1]);
        check_one("b_err_cnt",    32'(b_err),   m_err[1]);
        check_one("b_first_idx",  32'(b_fidx),  m_fidx[1]);
        check_one("b_first_gold", 32'(b_fgold), 32'(m_fgold[1]));
        check_one("b_first_gate", 32'(b_fgate), 32'(m_fgate[1]));
        check_one("b_vld_err",    32'(b_verr),  32'(m_verr[1]));
        check_one("b_diff_bits",  32'(b_diff),  32'(m_diff[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int i, input logic gv, input logic [W-1:0] gd, input logic [W-1:0] gc,
                         input logic tv, input logic [W-1:0] td);
        if (i == 0) begin
            bus_a.gold_vld = gv; bus_a.gold_data = gd; bus_a.gold_care = gc;
            bus_a.gate_vld = tv; bus_a.gate_data = td;
        end else begin
            bus_b.gold_vld = gv; bus_b.gold_data = gd; bus_b.gold_care = gc;
            bus_b.gate_vld = tv; bus_b.gate_data = td;
        end
    endtask

    task automatic model_both();
        model_step(0, arm_a, clear_a, bus_a.gold_vld, bus_a.gold_care, bus_a.gold_data,
                   bus_a.gate_vld, bus_a.gate_data);
        model_step(1, arm_b, clear_b, bus_b.gold_vld, bus_b.gold_care, bus_b.gold_data,
                   bus_b.gate_vld, bus_b.gate_data);
    endtask

    task automatic tick();
        model_both();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic fill_stream();
        for (int k = 0; k < 32; k++) begin
            sd[k] = 8'($urandom);
            sx[k] = '0;
        end
    endtask

    // n gold beats sd[0..n-1]; the gate copy (xor sx) follows lag cycles later.
    task automatic stream(input int i, input int n, input int lag, input logic [W-1:0] care);
        for (int t = 0; t < n + 4; t++) begin
            logic gv, tv;
            logic [W-1:0] gd, td;
            gv = (t < n);
            gd = gv ? sd[t] : '0;
            tv = 1'b0;
            td = '0;
            if (t >= lag && t - lag < n) begin
                tv = 1'b1;
                td = sd[t-lag] ^ sx[t-lag];
            end
            drive(i, gv, gd, care, tv, td);
            tick();
        end
        drive(i, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic pulse_clear(input int i);
        if (i == 0) begin arm_a = 1'b0; clear_a = 1'b1; end
        else        begin arm_b = 1'b0; clear_b = 1'b1; end
        tick();
        clear_a = 1'b0;
        clear_b = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    logic         pv [2][4];
    logic [W-1:0] pd [2][4];

    initial begin
        skew_of = '{SKEW_A, SKEW_B};
        cntw_of = '{CNTW_A, CNTW_B};
        stop_of = '{1'b0, 1'b1};
        arm_a = 1'b0; clear_a = 1'b0; arm_b = 1'b0; clear_b = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        model_reset();
        fill_stream();

        // Reset state
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_all();
        check_one("a_state_reset", 32'(a_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // B: ten identical beats 0x00..0x09, SKEW=0
        arm_b = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, 1'b1, 8'(k), 8'hFF, 1'b1, 8'(k));
            tick();
        end
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check_one("b_plan_chk10", 32'(b_chk), 32'd10);
        check_one("b_plan_err0",  32'(b_err), 32'd0);

        // B: error at beat 3 then more errors; stop-on-fail freezes everything
        pulse_clear(1);
        arm_b = 1'b1;
        tick();
        fill_stream();
        sd[3] = 8'hA5; sx[3] = 8'h01;
        for (int k = 4; k < 7; k++) sx[k] = 8'h10;
        stream(1, 7, 0, 8'hFF);
        check_one("b_stop_err",   32'(b_err),   32'd1);
        check_one("b_stop_chk",   32'(b_chk),   32'd4);
        check_one("b_stop_fidx",  32'(b_fidx),  32'd3);
        check_one("b_stop_gold",  32'(b_fgold), 32'hA5);
        check_one("b_stop_gate",  32'(b_fgate), 32'hA4);
        check_one("b_stop_state", 32'(b_state), 32'(FAIL));
        arm_b = 1'b0;
        ticks(2);
        check_one("b_fail_held",  32'(b_fail),  32'd1);
        pulse_clear(1);
        tick();
        check_one("b_clr_chk",    32'(b_chk),   32'd0);
        check_one("b_clr_fail",   32'(b_fail),  32'd0);

        // B: clear wins over a concurrent error
        arm_b = 1'b1;
        tick();
        drive(1, 1'b1, 8'h11, 8'hFF, 1'b1, 8'h22);
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
        arm_b = 1'b0;
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check_one("b_clr_prio_err", 32'(b_err), 32'd0);

        // A: gate lags gold by 2 (aligned), 5 matching beats, then re-arm accumulates
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        stream(0, 5, 2, 8'hFF);
        check_one("a_lag2_err", 32'(a_err), 32'd0);
        check_one("a_lag2_chk", 32'(a_chk), 32'd5);
        arm_a = 1'b0;
        tick();
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        stream(0, 3, 2, 8'hFF);
        check_one("a_accum_chk", 32'(a_chk), 32'd8);

        // A: gate lags by 1 -> valid-timing error on the first beat
        pulse_clear(0);
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        stream(0, 5, 1, 8'hFF);
        check_one("a_lag1_fail", 32'(a_fail), 32'd1);
        check_one("a_lag1_verr", 32'(a_verr), 32'd1);
        check_one("a_lag1_fidx", 32'(a_fidx), 32'd0);

        // A: beat 3 gold 0xA5 vs gate 0xA4 fully cared
        pulse_clear(0);
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        sd[3] = 8'hA5; sx[3] = 8'h01;
        stream(0, 6, 2, 8'hFF);
        check_one("a_b3_fidx", 32'(a_fidx),  32'd3);
        check_one("a_b3_gold", 32'(a_fgold), 32'hA5);
        check_one("a_b3_gate", 32'(a_fgate), 32'hA4);
        check_one("a_b3_err",  32'(a_err),   32'd1);

        // A: same beat with bit 0 masked -> no error
        pulse_clear(0);
        arm_a = 1'b1;
        ticks(3);
        stream(0, 6, 2, 8'hFE);
        check_one("a_mask_err",  32'(a_err),  32'd0);
        check_one("a_mask_fail", 32'(a_fail), 32'd0);

        // A: errors 0x01 then 0x80 build the diff map
        pulse_clear(0);
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        sd[0] = 8'h00; sx[0] = 8'h01;
        sd[1] = 8'h00; sx[1] = 8'h80;
        stream(0, 2, 2, 8'hFF);
`ifdef LOCKSTEP_MITER_DIFFMAP_EN
        check_one("a_diffmap", 32'(a_diff), 32'h81);
`else
        check_one("a_diffmap", 32'(a_diff), 32'h00);
`endif

        // A: 20 mismatching beats saturate the 4-bit counters
        pulse_clear(0);
        arm_a = 1'b1;
        ticks(3);
        fill_stream();
        for (int k = 0; k < 20; k++) sx[k] = 8'(1 << $urandom_range(7));
        stream(0, 20, 2, 8'hFF);
        check_one("a_sat_err",  32'(a_err),  32'd15);
        check_one("a_sat_chk",  32'(a_chk),  32'd15);
        check_one("a_sat_fidx", 32'(a_fidx), 32'd0);

        // Asynchronous reset in the middle of a checking session
        drive(0, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'h3C);
        tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check_one("a_rst_state", 32'(a_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        arm_a = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        tick();

        // Random traffic on both instances
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin pv[i][k] = 1'b0; pd[i][k] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                int           sk;
                logic         gv, tv, flip, clr;
                logic [W-1:0] gd, gc, td;
                sk   = (i == 0) ? SKEW_A : SKEW_B;
                flip = ($urandom_range(15) == 0);
                clr  = ($urandom_range(47) == 0);
                gv   = ($urandom_range(3) != 0);
                gd   = 8'($urandom);
                gc   = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom);
                for (int k = 3; k > 0; k--) begin pv[i][k] = pv[i][k-1]; pd[i][k] = pd[i][k-1]; end
                pv[i][0] = gv;
                pd[i][0] = gd;
                if ($urandom_range(7) != 0) begin
                    tv = pv[i][sk];
                    td = pd[i][sk];
                end else begin
                    tv = ($urandom_range(1) == 1);
                    td = 8'($urandom);
                end
                if ($urandom_range(7) == 0) td = td ^ 8'(1 << $urandom_range(7));
                drive(i, gv, gd, gc, tv, td);
                if (i == 0) begin
                    if (flip || c == 0) arm_a = ~arm_a | (c == 0);
                    clear_a = clr;
                end else begin
                    if (flip || c == 0) arm_b = ~arm_b | (c == 0);
                    clear_b = clr;
                end
            end
            tick();
        end
        clear_a = 1'b0; clear_b = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
